// File: rtl/synt_pkg.sv
// Shared constants and state encoding for the synthesizer power/cal sequencer.
package synt_pkg;

  localparam int CNT_W       = 12;
  localparam int RETRY_W     = 2;

  localparam int SETTLE_CYC  = 64;
  localparam int CAL_CYC     = 4;
  localparam int TIMEOUT_CYC = 2048;
  localparam int OFF_CYC     = 32;

  // Terminal-count values; each wait lasts exactly N cycles with the counter starting at 0.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CAL_LAST     = CNT_W'(CAL_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_CYC - 1);

  localparam logic [RETRY_W-1:0] MAX_RETRY  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWRUP    = 3'd1,
    ST_CAL      = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_RETRY    = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

endpackage

// File: rtl/synt_sync2.sv
// Generic two-flop synchroniser with async active-low reset to 0.
module synt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; q is the settled copy of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/synt_pwr_seq.sv
// Synthesizer power-up / calibration initiator with bounded waits and power-cycle retries.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | synth off, waiting for en_req
//  PWRUP    | pu_synt high, supply settling for SETTLE_CYC cycles
//  CAL      | cal_synt pulse, CAL_CYC cycles
//  WAIT_RDY | waiting for synchronised ready, bounded by TIMEOUT_CYC
//  LOCKED   | synth ready; losing ready triggers a power-cycle
//  RETRY    | pu_synt low for OFF_CYC cycles before the next attempt
//  FAIL     | retries exhausted; held until clr_err
module synt_pwr_seq
  import synt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic               clr_err,
  input  logic               rdy_synt,
  output logic               pu_synt,
  output logic               cal_synt,
  output logic               locked,
  output logic               err,
  output logic [RETRY_W-1:0] retry_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rdy_s;

  synt_sync2 u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rdy_synt),
    .q     (rdy_s)
  );

  // Next-state decode; dropping en_req wins over everything except FAIL.
  always_comb begin
    state_nxt = state;
    if (!en_req && state != ST_FAIL) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     state_nxt = ST_PWRUP;
        ST_PWRUP:    if (cnt == SETTLE_LAST) state_nxt = ST_CAL;
        ST_CAL:      if (cnt == CAL_LAST) state_nxt = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          // A ready arriving on the timeout cycle still counts as a lock.
          if (rdy_s)
            state_nxt = ST_LOCKED;
          else if (cnt == TIMEOUT_LAST)
            state_nxt = (retry_cnt < MAX_RETRY) ? ST_RETRY : ST_FAIL;
        end
        ST_LOCKED:   if (!rdy_s) state_nxt = ST_RETRY;
        ST_RETRY:    if (cnt == OFF_LAST) state_nxt = ST_PWRUP;
        ST_FAIL:     if (clr_err) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register with outputs decoded from the next state so they switch with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pu_synt  <= 1'b0;
      cal_synt <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pu_synt  <= (state_nxt == ST_PWRUP) || (state_nxt == ST_CAL) ||
                  (state_nxt == ST_WAIT_RDY) || (state_nxt == ST_LOCKED);
      cal_synt <= (state_nxt == ST_CAL);
      locked   <= (state_nxt == ST_LOCKED);
      err      <= (state_nxt == ST_FAIL);
    end
  end

  // Shared cycle counter: cleared on every state change, runs only in timed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_PWRUP || state == ST_CAL ||
                 state == ST_WAIT_RDY || state == ST_RETRY) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Retry counter: cleared on abort, new bring-up and lock; bumped on entering RETRY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (!en_req && state != ST_FAIL) begin
      retry_cnt <= '0;
    end else if ((state == ST_IDLE && state_nxt == ST_PWRUP) || state_nxt == ST_LOCKED) begin
      retry_cnt <= '0;
    end else if (state_nxt == ST_RETRY && state != ST_RETRY) begin
      if (retry_cnt != MAX_RETRY)
        retry_cnt <= retry_cnt + 1'b1;
    end
  end

endmodule
